bsg_manycore_host_mmio_responder: RTL
=====================================

# bsg_manycore_host_mmio_responder

Responder at the host IO coordinate of the manycore network: accepts remote load/store requests issued by tiles toward the host, decodes a small MMIO register map (finish, fail, putchar, print-stat, scratch, status), and returns one response packet per request. It is the receiving end of the traffic that the host-side DPI endpoint injects in the other direction. Host-facing outputs (finish/fail flags, character stream, print-stat pulses) feed the cosimulation harness and the stat snoop logic.

## Interface
- addr_width_p, 28: EPA (word address) width of requests
- data_width_p, 32: request/response data width; must be a multiple of 8
- x_cord_width_p, 7: tile X coordinate width
- y_cord_width_p, 7: tile Y coordinate width
- char_fifo_els_p, 16: putchar FIFO depth; power of two, >= 2

- clk_i  in  1  core clock
- reset_n_i  in  1  asynchronous, active-low reset
- req_v_i  in  1  request valid
- req_ready_o  out  1  request ready; transfer on req_v_i & req_ready_o
- req_store_i  in  1  1 = store, 0 = load
- req_addr_i  in  addr_width_p  EPA word address
- req_data_i  in  data_width_p  store data
- req_mask_i  in  data_width_p/8  store byte mask
- req_src_x_i / req_src_y_i  in  x/y_cord_width_p  requester coordinate
- req_reg_id_i  in  5  requester register id
- rsp_v_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when rsp_v_o & rsp_ready_i
- rsp_load_o  out  1  1 = load data response, 0 = store credit
- rsp_data_o  out  data_width_p  load data (0 for credits)
- rsp_dst_x_o / rsp_dst_y_o  out  x/y_cord_width_p  echo of requester coordinate
- rsp_reg_id_o  out  5  echo of req_reg_id_i
- finish_v_o  out  1  sticky: a FINISH store occurred
- finish_code_o  out  data_width_p  data of first FINISH store
- fail_v_o  out  1  sticky: a FAIL store occurred
- char_v_o  out  1  char FIFO non-empty
- char_o  out  8  FIFO head byte
- char_yumi_i  in  1  pop char FIFO; legal only when char_v_o
- print_stat_v_o  out  1  one-cycle pulse per PRINT_STAT store
- print_stat_tag_o  out  data_width_p  tag of last PRINT_STAT store
- err_o  out  1  sticky: unmapped address or store to read-only register

## Operation
- Word-offset map on req_addr_i: 0 FINISH (W), 1 FAIL (W), 2 PUTCHAR (W, byte 0 only), 3 PRINT_STAT (W), 4 SCRATCH (RW, byte-masked stores), 5 STATUS (RO). Other addresses unmapped.
- STATUS read value: bit0 finish_v, bit1 fail_v, bits [2+:$clog2(char_fifo_els_p)+1] FIFO occupancy, rest 0.
- Loads of W-only registers and unmapped addresses return 0; unmapped loads/stores and stores to STATUS set err_o and have no other side effect. Every accepted request gets exactly one response, errors included.
- FINISH: first store sets finish_v_o and captures code; later FINISH stores are credited but do not change the code. FAIL: sets fail_v_o.
- Masks ignored for FINISH/FAIL/PUTCHAR/PRINT_STAT; honoured for SCRATCH.
- Response slot state machine: EMPTY -> FULL on accept; FULL -> EMPTY on drain without accept; FULL stays FULL on drain and accept in the same cycle (slot reloaded).

## Timing
- req_ready_o = (EMPTY | rsp_ready_i) & ~(PUTCHAR store addressed & FIFO full); combinational from request fields, no same-cycle pop credit.
- Response and all side effects registered: visible the cycle after acceptance (latency 1). Back-to-back throughput 1/cycle while rsp_ready_i held high.
- SCRATCH store followed immediately by SCRATCH load returns the new value.
- Simultaneous PUTCHAR push and char_yumi_i on non-empty FIFO: both take effect, occupancy unchanged.
- Reset (any time, asynchronous): response slot EMPTY, rsp_v_o/finish_v_o/fail_v_o/char_v_o/print_stat_v_o/err_o = 0, finish_code_o/print_stat_tag_o/SCRATCH = 0, FIFO empty; in-flight response dropped.

## Structure
- Package bsg_manycore_host_mmio_pkg: register-offset enum, STATUS bit positions, response-type constants.
- Char FIFO: one bsg_fifo_1r1w_small instance (width 8, els char_fifo_els_p); everything else in the top module.

## Test plan
- Store 0x2A to FINISH, then 0x99 to FINISH -> two credits, finish_v_o=1, finish_code_o=0x2A.
- Store 0xDEADBEEF to SCRATCH, mask 0b0011 store 0x00001234, load -> rsp_data_o=0xDEAD1234, rsp_load_o=1.
- Push char_fifo_els_p+1 PUTCHARs with char_yumi_i=0 -> last stalls (req_ready_o=0) until one pop, then accepted; bytes emerge in order.
- Hold rsp_ready_i=0 for 5 cycles with requests pending -> one response held stable, req_ready_o=0; release -> 1/cycle throughput.
- Load address 9 and store to STATUS -> responses with data 0, err_o=1; STATUS load reflects FIFO count.
- Assert reset_n_i low while rsp_v_o=1 and FIFO holds 3 chars -> all outputs 0 immediately, no response after release.

Source files
------------

// File: rtl/bsg_manycore_host_mmio_pkg.sv
// bsg_manycore_host_mmio_pkg: register map, STATUS layout and response types for the host MMIO responder.
package bsg_manycore_host_mmio_pkg;
  typedef enum logic [2:0] {
    REG_FINISH     = 3'd0,
    REG_FAIL       = 3'd1,
    REG_PUTCHAR    = 3'd2,
    REG_PRINT_STAT = 3'd3,
    REG_SCRATCH    = 3'd4,
    REG_STATUS     = 3'd5
  } reg_off_e;
  localparam int REG_NUM = 6;
  localparam int STATUS_FINISH_BIT = 0;
  localparam int STATUS_FAIL_BIT = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam logic RSP_CREDIT = 1'b0;
  localparam logic RSP_LOAD = 1'b1;
endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small circular FIFO with occupancy count; ready reflects only the registered count.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p = 16,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  output logic                 ready_o,
  input  logic [width_p-1:0]   data_i,
  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  input  logic                 yumi_i,
  output logic [lg_els_lp:0]   count_o
);
  logic [width_p-1:0] mem [els_p];
  logic [lg_els_lp-1:0] wptr, rptr;
  logic push, pop;
  assign ready_o = count_o != (lg_els_lp+1)'(els_p);
  assign v_o = count_o != '0;
  assign data_o = mem[rptr];
  assign push = v_i & ready_o;
  assign pop = yumi_i & v_o;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      count_o <= '0;
    end else begin
      wptr <= wptr + lg_els_lp'(push);
      rptr <= rptr + lg_els_lp'(pop);
      count_o <= count_o + (lg_els_lp+1)'(push) - (lg_els_lp+1)'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= data_i;
endmodule

// File: rtl/bsg_manycore_host_mmio_responder.sv
// bsg_manycore_host_mmio_responder: host-coordinate MMIO endpoint answering tile loads/stores with one response each.
module bsg_manycore_host_mmio_responder
  import bsg_manycore_host_mmio_pkg::*;
#(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int char_fifo_els_p = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      req_v_i,
  output logic                      req_ready_o,
  input  logic                      req_store_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [data_width_p/8-1:0] req_mask_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  input  logic [4:0]                req_reg_id_i,
  output logic                      rsp_v_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_load_o,
  output logic [data_width_p-1:0]   rsp_data_o,
  output logic [x_cord_width_p-1:0] rsp_dst_x_o,
  output logic [y_cord_width_p-1:0] rsp_dst_y_o,
  output logic [4:0]                rsp_reg_id_o,
  output logic                      finish_v_o,
  output logic [data_width_p-1:0]   finish_code_o,
  output logic                      fail_v_o,
  output logic                      char_v_o,
  output logic [7:0]                char_o,
  input  logic                      char_yumi_i,
  output logic                      print_stat_v_o,
  output logic [data_width_p-1:0]   print_stat_tag_o,
  output logic                      err_o
);
  localparam int cnt_w_lp = $clog2(char_fifo_els_p) + 1;
  typedef enum logic {EMPTY, FULL} slot_e;
  slot_e state;
  reg_off_e off;
  logic mapped, is_fin, is_fail, is_put, is_ps, is_scr, is_status;
  logic accept, st_acc, fifo_ready;
  logic [cnt_w_lp-1:0] count;
  logic [data_width_p-1:0] scratch, scratch_n, status, load_data;
  assign mapped = req_addr_i < addr_width_p'(REG_NUM);
  assign off = reg_off_e'(req_addr_i[2:0]);
  assign is_fin = mapped & (off == REG_FINISH);
  assign is_fail = mapped & (off == REG_FAIL);
  assign is_put = mapped & (off == REG_PUTCHAR);
  assign is_ps = mapped & (off == REG_PRINT_STAT);
  assign is_scr = mapped & (off == REG_SCRATCH);
  assign is_status = mapped & (off == REG_STATUS);
  // A full char FIFO stalls only PUTCHAR stores; a pop this cycle does not free a slot until next cycle.
  assign req_ready_o = ((state == EMPTY) | rsp_ready_i) & ~(req_store_i & is_put & ~fifo_ready);
  assign accept = req_v_i & req_ready_o;
  assign st_acc = accept & req_store_i;
  assign rsp_v_o = state == FULL;
  always_comb begin
    scratch_n = scratch;
    for (int i = 0; i < data_width_p/8; i++)
      if (req_mask_i[i]) scratch_n[8*i+:8] = req_data_i[8*i+:8];
    status = '0;
    status[STATUS_FINISH_BIT] = finish_v_o;
    status[STATUS_FAIL_BIT] = fail_v_o;
    status[STATUS_COUNT_LSB+:cnt_w_lp] = count;
    load_data = is_scr ? scratch : is_status ? status : '0;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= EMPTY;
      rsp_load_o <= RSP_CREDIT;
      rsp_data_o <= '0;
      rsp_dst_x_o <= '0;
      rsp_dst_y_o <= '0;
      rsp_reg_id_o <= '0;
      finish_v_o <= 1'b0;
      finish_code_o <= '0;
      fail_v_o <= 1'b0;
      print_stat_v_o <= 1'b0;
      print_stat_tag_o <= '0;
      err_o <= 1'b0;
      scratch <= '0;
    end else begin
      if (accept) begin
        state <= FULL;
        rsp_load_o <= req_store_i ? RSP_CREDIT : RSP_LOAD;
        rsp_data_o <= req_store_i ? '0 : load_data;
        rsp_dst_x_o <= req_src_x_i;
        rsp_dst_y_o <= req_src_y_i;
        rsp_reg_id_o <= req_reg_id_i;
      end else if (rsp_ready_i) state <= EMPTY;
      print_stat_v_o <= st_acc & is_ps;
      if (st_acc & is_fin & ~finish_v_o) begin
        finish_v_o <= 1'b1;
        finish_code_o <= req_data_i;
      end
      if (st_acc & is_fail) fail_v_o <= 1'b1;
      if (st_acc & is_ps) print_stat_tag_o <= req_data_i;
      if (st_acc & is_scr) scratch <= scratch_n;
      if (accept & (~mapped | (req_store_i & is_status))) err_o <= 1'b1;
    end
  bsg_fifo_1r1w_small #(.width_p(8), .els_p(char_fifo_els_p)) char_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (st_acc & is_put),
    .ready_o  (fifo_ready),
    .data_i   (req_data_i[7:0]),
    .v_o      (char_v_o),
    .data_o   (char_o),
    .yumi_i   (char_yumi_i),
    .count_o  (count)
  );
endmodule
